// File: rtl/rs232in_fifo_pkg.sv
// Shared constants for the rs232in receive FIFO and the rs232 register block.
package rs232in_fifo_pkg;
  localparam int DEPTH_LOG2_DEF = 4;
  // rs232 peripheral register offsets for the receive side
  localparam logic [3:0] RS232IN_DATA_OFS  = 4'd1;
  localparam logic [3:0] RS232IN_COUNT_OFS = 4'd2;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/rs232in_fifo_if.sv
// Handshake bundle between rs232in/rs232 (master side) and the receive FIFO.
interface rs232in_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic                  in_attention;
  logic [7:0]            in_data;
  logic                  rd;
  logic                  clr_overrun;
  logic [7:0]            rd_data;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overrun;

  modport master (output in_attention, in_data, rd, clr_overrun,
                  input  rd_data, count, empty, full, overrun);
  modport slave  (input  in_attention, in_data, rd, clr_overrun,
                  output rd_data, count, empty, full, overrun);
endinterface

// File: rtl/rs232in_fifo_regfile.sv
// 2^AW x 8 register array: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/rs232in_fifo.sv
// Receive FIFO behind rs232in: captures attention strobes, FWFT head, count, sticky overrun.
module rs232in_fifo
  import rs232in_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic           clk,
  input  logic           rst,
  rs232in_fifo_if.slave  bus
);
  localparam int                CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]     DEPTH = CW'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overrun;
  logic                  empty, full;
  logic                  pop_ok, push_ok, drop;
  byte_t                 head;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign pop_ok  = bus.rd && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = bus.in_attention && (!full || pop_ok);
  assign drop    = bus.in_attention && !push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      // set beats clear when both land together
      if (drop)                 overrun <= 1'b1;
      else if (bus.clr_overrun) overrun <= 1'b0;
    end
  end

  fifo_regfile #(.AW(DEPTH_LOG2)) u_rf (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.rd_data = empty ? 8'h00 : head;
  assign bus.count   = count;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.overrun = overrun;
endmodule
